// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver.
//   - parity mode encodings
//   - receiver FSM state encoding
//   - width rule of one FIFO entry: {ferr, perr, data}
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // One received frame as stored in the FIFO: {ferr, perr, data[DATA_BITS-1:0]}.
  function automatic int rx_entry_width(input int data_bits);
    return data_bits + 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO holding received frames.
// Ports:
//   CLK, RST      clock, asynchronous active-high reset (FIFO empties)
//   push, din     write request / data; ignored when full unless popping too
//   pop           read request; ignored when empty
//   full, empty   occupancy flags (registered count)
//   dout          head entry, forced to 0 while empty
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with error flags and an output FIFO.
// Ports:
//   CLK, RST   clock, asynchronous active-high reset
//   UART_RX    asynchronous serial line, idles high
//   rx_data    head-of-FIFO data (show-ahead)
//   rx_perr    parity error flag of head entry
//   rx_ferr    framing error flag of head entry
//   rx_valid   FIFO not empty
//   rx_ready   consumer pop (rx_valid && rx_ready consumes the head)
//   overrun    one-cycle pulse when a finished frame is dropped on a full FIFO
//   busy       receiver FSM not idle
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = PARITY_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int EW = rx_entry_width(DATA_BITS);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] SAMPLE_PT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  rx_state_t state, nxt;

  logic                 sync1, sync2, prev;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q, ferr_q, done_q;
  logic                 push;
  logic                 sample, fall, last_stop, par_err;
  logic                 fifo_full, fifo_empty;
  logic [EW-1:0]        fifo_dout;

  assign sample    = (cnt == SAMPLE_PT);
  assign fall      = prev & ~sync2;
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
  // XOR over data and parity bit is 0 for a correct even frame, 1 for odd.
  assign par_err   = (PARITY_MODE == PARITY_EVEN) ? (^shreg ^ sync2) : ~(^shreg ^ sync2);
  assign busy      = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt  = state;
    push = 1'b0;
    unique case (state)
      IDLE:   if (fall) nxt = START;
      START:  if (sample) nxt = sync2 ? IDLE : DATA;
      DATA:   if (sample && bit_idx == LAST_BIT)
                nxt = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
      PARITY: if (sample) nxt = STOP;
      // done_q marks the cycle after the last stop sample: push and leave.
      STOP:   if (done_q) begin
                push = 1'b1;
                nxt  = IDLE;
              end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      prev     <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      done_q   <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      sync1   <= UART_RX;
      sync2   <= sync1;
      prev    <= sync2;
      overrun <= push & fifo_full & ~rx_ready;
      // Held at 0 in IDLE so START always begins from a cleared counter.
      if (state == IDLE || cnt == CNT_MAX) cnt <= '0;
      else                                 cnt <= cnt + CW'(1);
      unique case (state)
        START: if (sample) begin
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          perr_q   <= 1'b0;
          ferr_q   <= 1'b0;
          done_q   <= 1'b0;
        end
        DATA: if (sample) begin
          shreg   <= {sync2, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + BW'(1);
        end
        PARITY: if (sample) perr_q <= par_err;
        STOP: begin
          if (done_q) begin
            done_q <= 1'b0;
          end else if (sample) begin
            if (!sync2) ferr_q <= 1'b1;
            if (last_stop) done_q   <= 1'b1;
            else           stop_idx <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (rx_ready),
    .din   ({ferr_q, perr_q, shreg}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign rx_valid = ~fifo_empty;
  assign rx_ferr  = fifo_dout[EW-1];
  assign rx_perr  = fifo_dout[EW-2];
  assign rx_data  = fifo_dout[DATA_BITS-1:0];

endmodule
